fetch_ctrl: RTL and testbench

- Sequences the instruction-fetch stage: owns the PC, issues one-at-a-time requests to instruction memory, and fills the IF→ID pipeline register feeding decode.
- Handles decode back-pressure (stall) and branch/jump redirects (flush), discarding stale in-flight fetches.
- Sits between the fetch stage, instruction memory, and the decode stage inside the core top.

---
 rtl/fetch_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the PC, keeps at most one request to instruction memory in flight,
// and fills the IF/ID register. Decode stalls park a returning instruction
// in a one-entry hold buffer. Redirects flush IF/ID and discard stale fetches.
//
// Ports:
//   clock, reset                 core clock (rising edge), async active-low reset
//   imem_req_valid/ready/addr    fetch request handshake
//   imem_resp_valid/data         fetch response, one pulse per accepted request
//   id_valid/id_pc/id_inst       IF/ID pipeline register (registered)
//   id_ready                     decode consumes IF/ID this cycle
//   redirect_valid/redirect_pc   flush and restart fetch at redirect_pc

module fetch_ctrl #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    input  logic            id_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_KILL
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [XLEN-1:0] hold_inst_q, hold_inst_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_inst_q, id_inst_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;

    logic            accept;
    logic [XLEN-1:0] redir_target;
    logic            unused_redirect_lsbs;

    assign accept               = req_valid_q && imem_req_ready;
    assign redir_target         = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Next-state, PC, hold buffer and IF/ID update.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;

        // IF/ID drains on consumption unless a load below refills it.
        if (id_valid_q && id_ready) begin
            id_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (accept) begin
                    pc_d     = pc_q + XLEN'(4);
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (!id_valid_q || id_ready) begin
                        id_valid_d = 1'b1;
                        id_pc_d    = req_pc_q;
                        id_inst_d  = imem_resp_data;
                        state_d    = S_REQ;
                    end else begin
                        hold_pc_d   = req_pc_q;
                        hold_inst_d = imem_resp_data;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (id_ready) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = hold_pc_q;
                    id_inst_d  = hold_inst_q;
                    state_d    = S_REQ;
                end
            end
            S_KILL: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides everything; a fetch still in flight must be drained in KILL.
        if (redirect_valid) begin
            pc_d       = redir_target;
            id_valid_d = 1'b0;
            id_pc_d    = id_pc_q;
            id_inst_d  = id_inst_q;
            case (state_q)
                S_REQ:   state_d = accept ? S_KILL : S_REQ;
                S_WAIT:  state_d = imem_resp_valid ? S_REQ : S_KILL;
                S_KILL:  state_d = imem_resp_valid ? S_REQ : S_KILL;
                default: state_d = S_REQ;
            endcase
        end

        req_valid_d = (state_d == S_REQ);
        req_addr_d  = pc_d;
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            hold_pc_q   <= '0;
            hold_inst_q <= '0;
            id_valid_q  <= 1'b0;
            id_pc_q     <= '0;
            id_inst_q   <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;
    assign id_inst        = id_inst_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl.
// A transaction-level model tracks the expected next request address and the
// expected program-order PC stream at decode; a small memory model answers
// accepted requests after a chosen latency. Directed phases pin exact cycles.

module tb_fetch_ctrl;

    localparam int unsigned XLEN = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid = 1'b0;
    logic [XLEN-1:0] imem_resp_data = '0;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_inst;
    logic            id_ready = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;

    fetch_ctrl #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clock = ~clock;

    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc   = -1;

    logic [31:0] exp_req, exp_id;
    bit          mem_busy;
    int          mem_due;
    logic [31:0] mem_addr;
    bit          exp_flush, exp_stable;
    logic [31:0] st_pc, st_inst;

    logic        s_rv, s_iv;
    logic [31:0] s_ra, s_ip, s_ii;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        imem_req_ready  = 1'b0;
        id_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'hDEAD_BEEF;
        mem_busy        = 1'b0;
        exp_flush       = 1'b0;
        exp_stable      = 1'b0;
        exp_req         = 32'h0;
        exp_id          = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst req_valid", imem_req_valid, 0);
        chk("rst req_addr", imem_req_addr, 32'h0);
        chk("rst id_valid", id_valid, 0);
        chk("rst id_pc", id_pc, 32'h0);
        chk("rst id_inst", id_inst, 32'h0);
        @(posedge clock);
        #1 reset = 1'b1;
        cyc = -1;
    endtask

    // One clock cycle: sample and check at the falling edge, drive inputs,
    // then advance the model to what the next rising edge must produce.
    task automatic step(input bit rdy, input bit idr, input bit rv,
                        input logic [31:0] rpc, input int lat);
        logic [31:0] tgt;
        bit          acc, cons;
        @(negedge clock);
        cyc++;
        s_rv = imem_req_valid;
        s_ra = imem_req_addr;
        s_iv = id_valid;
        s_ip = id_pc;
        s_ii = id_inst;

        if (exp_flush) chk("flush id_valid", s_iv, 0);
        if (exp_stable) begin
            chk("stall id_valid", s_iv, 1);
            chk("stall id_pc", s_ip, st_pc);
            chk("stall id_inst", s_ii, st_inst);
        end
        if (s_rv) chk("req_addr", s_ra, exp_req);

        imem_req_ready = rdy;
        id_ready       = idr;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (mem_busy && cyc >= mem_due) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_addr);
            mem_busy        = 1'b0;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end

        acc  = s_rv && rdy;
        cons = s_iv && idr && !rv;
        if (cons) begin
            chk("id_pc", s_ip, exp_id);
            chk("id_inst", s_ii, mem_word(exp_id));
            exp_id = exp_id + 32'd4;
        end
        if (acc) begin
            chk("one outstanding", 32'(mem_busy), 0);
            mem_busy = 1'b1;
            mem_due  = cyc + lat;
            mem_addr = s_ra;
            exp_req  = exp_req + 32'd4;
        end
        exp_flush  = rv;
        exp_stable = s_iv && !idr && !rv;
        st_pc      = s_ip;
        st_inst    = s_ii;
        if (rv) begin
            tgt     = {rpc[31:2], 2'b00};
            exp_req = tgt;
            exp_id  = tgt;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        // Zero-wait throughput, then redirect while waiting on 0x8.
        do_reset();
        for (int k = 0; k <= 12; k++) begin
            step(1'b1, 1'b1, k == 6, 32'h0000_1002, (k == 5) ? 2 : 1);
            case (k)
                0: chk("A idle req_valid", s_rv, 0);
                1: begin chk("A c1 req_valid", s_rv, 1); chk("A c1 addr", s_ra, 32'h0); end
                2: chk("A c2 req_valid", s_rv, 0);
                3: begin
                    chk("A c3 addr", s_ra, 32'h4);
                    chk("A c3 id_valid", s_iv, 1);
                    chk("A c3 id_pc", s_ip, 32'h0);
                    chk("A c3 id_inst", s_ii, mem_word(32'h0));
                end
                5: begin chk("A c5 req_valid", s_rv, 1); chk("A c5 addr", s_ra, 32'h8); end
                7: begin chk("A kill id_valid", s_iv, 0); chk("A kill req_valid", s_rv, 0); end
                8: begin chk("A redir req_valid", s_rv, 1); chk("A redir addr", s_ra, 32'h1000); end
                10: begin chk("A c10 id_valid", s_iv, 1); chk("A c10 id_pc", s_ip, 32'h1000); end
                default: ;
            endcase
        end

        // Decode stall parks the second instruction in the hold buffer.
        do_reset();
        for (int k = 0; k <= 13; k++) begin
            step(1'b1, !(k >= 3 && k <= 8), 1'b0, 32'h0, 1);
            if (k >= 4 && k <= 9) chk("B no req in hold", s_rv, 0);
            case (k)
                9:  chk("B c9 id_pc", s_ip, 32'h0);
                10: begin chk("B c10 id_pc", s_ip, 32'h4); chk("B c10 addr", s_ra, 32'h8); end
                12: begin chk("B c12 id_pc", s_ip, 32'h8); chk("B c12 addr", s_ra, 32'hC); end
                default: ;
            endcase
        end

        // Redirect in the same cycle as the response for 0x4.
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            step(1'b1, 1'b1, k == 4, 32'h0000_2000, 1);
            case (k)
                5: begin
                    chk("C c5 req_valid", s_rv, 1);
                    chk("C c5 addr", s_ra, 32'h2000);
                    chk("C c5 id_valid", s_iv, 0);
                end
                7: begin chk("C c7 id_valid", s_iv, 1); chk("C c7 id_pc", s_ip, 32'h2000); end
                default: ;
            endcase
        end

        // Memory not ready for five cycles, redirect during the wait.
        do_reset();
        for (int k = 0; k <= 9; k++) begin
            step(!(k >= 1 && k <= 5), 1'b1, k == 3, 32'h0000_3000, 1);
            if (k >= 1 && k <= 3) begin
                chk("D stall req_valid", s_rv, 1);
                chk("D stall addr", s_ra, 32'h0);
            end
            if (k >= 4 && k <= 6) begin
                chk("D redir req_valid", s_rv, 1);
                chk("D redir addr", s_ra, 32'h3000);
            end
            if (k == 8) chk("D c8 addr", s_ra, 32'h3004);
        end

        // PC wrap after redirect+accept, then async reset in WAIT.
        do_reset();
        for (int k = 0; k <= 6; k++) begin
            step(1'b1, 1'b1, k == 1, 32'hFFFF_FFFE, (k == 5) ? 3 : 1);
            case (k)
                2: chk("E kill req_valid", s_rv, 0);
                3: chk("E c3 addr", s_ra, 32'hFFFF_FFFC);
                5: begin
                    chk("E wrap addr", s_ra, 32'h0);
                    chk("E c5 id_valid", s_iv, 1);
                    chk("E c5 id_pc", s_ip, 32'hFFFF_FFFC);
                end
                default: ;
            endcase
        end
        #2 reset = 1'b0;
        #1;
        chk("E async req_valid", imem_req_valid, 0);
        chk("E async req_addr", imem_req_addr, 32'h0);
        chk("E async id_valid", id_valid, 0);
        chk("E async id_pc", id_pc, 32'h0);
        chk("E async id_inst", id_inst, 32'h0);
        do_reset();
        for (int k = 0; k <= 2; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1);
            if (k == 1) begin chk("E first req_valid", s_rv, 1); chk("E first addr", s_ra, 32'h0); end
        end

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                             : ($urandom & 32'h0000_FFFF);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 99) < 7, rpc, $urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
